// File: rtl/counter_seq_checker.sv
// ---------------------------------------------------------------------------
// counter_seq_checker
//
// Self-check monitor for a 3-bit up/down counter.
//
// The block samples `count` and `mode` on every clock where `valid` is high.
// It predicts the next legal counter value and flags any illegal step.
// It counts mismatches (saturating) and legal wraps (rolling over).
// It drives status outputs only and never back-pressures the counter.
//
// Parameters
//   ERR_W      width of the saturating error counter
//   WRAP_W     width of the wrap counter (wraps modulo 2^WRAP_W)
//   ERR_LIMIT  error count that forces FAULT; 0 = never fault
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset (overrides valid)
//   valid       in   sample enable; count/mode are ignored when 0
//   mode        in   counter direction: 0 = up mod 8, 1 = down mod 8
//   count       in   counter value under check
//   seq_ok      out  1 while tracking and the last compared sample matched
//   err_pulse   out  one-cycle pulse per mismatch
//   err_count   out  saturating mismatch count
//   wrap_count  out  legal wraps seen (7->0 going up, 0->7 going down)
//   fault       out  sticky; set on entry to FAULT, cleared only by reset
//
// Optional feature (macro CHK_LAST_ERR_EN)
//   When defined, the block adds the outputs last_exp[2:0] and last_obs[2:0].
//   They capture the expected and the observed value on every mismatch.
//   When undefined, these ports and their registers do not exist.
// ---------------------------------------------------------------------------
module counter_seq_checker #(
   parameter int ERR_W     = 8,
   parameter int WRAP_W    = 8,
   parameter int ERR_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic              mode,
   input  logic [2:0]        count,
   output logic              seq_ok,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              fault
`ifdef CHK_LAST_ERR_EN
   ,
   output logic [2:0]        last_exp,
   output logic [2:0]        last_obs
`endif
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
   localparam logic [31:0]      LIMIT   = 32'(ERR_LIMIT);

   state_t            state_q,      state_d;
   logic [2:0]        exp_q,        exp_d;
   logic              mode_q,       mode_d;
   logic              seq_ok_q,     seq_ok_d;
   logic              err_pulse_q,  err_pulse_d;
   logic [ERR_W-1:0]  err_count_q,  err_count_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
   logic              fault_q,      fault_d;
`ifdef CHK_LAST_ERR_EN
   logic [2:0]        last_exp_q,   last_exp_d;
   logic [2:0]        last_obs_q,   last_obs_d;
`endif

   // The counter's successor of value c in direction m, with a 3-bit wrap.
   function automatic logic [2:0] next_val(input logic [2:0] c, input logic m);
      return m ? (c - 3'd1) : (c + 3'd1);
   endfunction

   logic [2:0]       obs_next;
   logic [ERR_W-1:0] err_inc;
   logic             hit;
   logic             wrap_hit;

   always_comb begin
      obs_next = next_val(count, mode);
      // Hold at the maximum value instead of wrapping back to zero.
      err_inc  = (err_count_q == ERR_MAX) ? err_count_q : (err_count_q + 1'b1);
      hit      = (count == exp_q);
      // A matched sample is a legal wrap when the predicted value was the
      // far end of the range for the current direction.
      wrap_hit = hit && (( !mode && (exp_q == 3'd0)) ||
                         (  mode && (exp_q == 3'd7)));
   end

   always_comb begin
      state_d      = state_q;
      exp_d        = exp_q;
      mode_d       = mode_q;
      seq_ok_d     = seq_ok_q;
      err_pulse_d  = 1'b0;
      err_count_d  = err_count_q;
      wrap_count_d = wrap_count_q;
      fault_d      = fault_q;
`ifdef CHK_LAST_ERR_EN
      last_exp_d   = last_exp_q;
      last_obs_d   = last_obs_q;
`endif

      if (valid) begin
         unique case (state_q)
            SYNC: begin
               // The first sample only seeds the prediction.
               exp_d   = obs_next;
               mode_d  = mode;
               state_d = TRACK;
            end

            TRACK: begin
               if (mode != mode_q) begin
                  // A direction change takes priority over a compare.
                  // Re-seed from this sample and do not report an error.
                  exp_d    = obs_next;
                  mode_d   = mode;
                  seq_ok_d = 1'b0;
               end else if (hit) begin
                  seq_ok_d = 1'b1;
                  exp_d    = obs_next;
                  if (wrap_hit) begin
                     wrap_count_d = wrap_count_q + 1'b1;
                  end
               end else begin
                  // Mismatch: count it, then re-seed from the observed value.
                  // One glitch therefore yields one error, not a cascade.
                  err_pulse_d = 1'b1;
                  seq_ok_d    = 1'b0;
                  err_count_d = err_inc;
                  exp_d       = obs_next;
`ifdef CHK_LAST_ERR_EN
                  last_exp_d  = exp_q;
                  last_obs_d  = count;
`endif
                  if ((ERR_LIMIT != 0) && (32'(err_inc) >= LIMIT)) begin
                     state_d = FAULT;
                     fault_d = 1'b1;
                  end
               end
            end

            FAULT: begin
               // Terminal state. Only reset leaves it.
               seq_ok_d = 1'b0;
            end

            default: begin
               state_d = SYNC;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= SYNC;
         exp_q        <= 3'd0;
         mode_q       <= 1'b0;
         seq_ok_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_count_q  <= '0;
         wrap_count_q <= '0;
         fault_q      <= 1'b0;
`ifdef CHK_LAST_ERR_EN
         last_exp_q   <= 3'd0;
         last_obs_q   <= 3'd0;
`endif
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         mode_q       <= mode_d;
         seq_ok_q     <= seq_ok_d;
         err_pulse_q  <= err_pulse_d;
         err_count_q  <= err_count_d;
         wrap_count_q <= wrap_count_d;
         fault_q      <= fault_d;
`ifdef CHK_LAST_ERR_EN
         last_exp_q   <= last_exp_d;
         last_obs_q   <= last_obs_d;
`endif
      end
   end

   assign seq_ok     = seq_ok_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;
   assign fault      = fault_q;
`ifdef CHK_LAST_ERR_EN
   assign last_exp   = last_exp_q;
   assign last_obs   = last_obs_q;
`endif

endmodule
